cordic_gain_comp: RTL and testbench
===================================

Name: cordic_gain_comp

Overview:
- Downstream consumer of the iterative CORDIC engine inside the TinyQV CORDIC peripheral.
- Captures out1/out2 on the engine's 1-cycle done pulse and removes the CORDIC gain by a serial shift-add multiply with a mode-dependent constant K.
- Rounds and saturates the result, then presents it on a valid/ready interface to the register/readback logic.
- The peripheral wrapper can then expose true cos/sin, magnitude and cosh/sinh values instead of gain-scaled ones.

Parameters:
- FIXED_WIDTH, 16, width of signed data words; the 1.0 position is irrelevant because K is a pure scalar.
- K_W, 18, coefficient width, unsigned Q2.16.
- K_FRAC, 16, fractional bits of K.
- K_CIRC, 18'h09B75, 0.607253 (1/circular gain).
- K_HYP, 18'h1351E, 1.207497 (1/hyperbolic gain).

Ports:
- clk  in  1  peripheral clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  engine done pulse; no backpressure upstream.
- in_mode  in  2  0 circular, 1 linear, 2 hyperbolic, 3 reserved (treated as linear).
- in_rotating  in  1  1 rotation, 0 vectoring.
- in_a  in  FIXED_WIDTH  engine out1, signed.
- in_b  in  FIXED_WIDTH  engine out2, signed.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out1  out  FIXED_WIDTH  compensated first result.
- out2  out  FIXED_WIDTH  compensated or passed-through second result.
- out_sat  out  1  either output was clipped.
- busy  out  1  state is not IDLE.
- overrun  out  1  sticky: an input was dropped.
- clr_overrun  in  1  clears overrun.

Behaviour:
- Reset: state IDLE, out_valid=0, out1=out2=0, out_sat=0, overrun=0, counter=0. Reset at any point, including mid-multiply, aborts the operation and discards its result.
- States: IDLE, MUL, OUT.
- IDLE, in_valid=1:
  - Latch inputs, mode and rotating.
  - Circular/hyperbolic: next state MUL, counter=0.
  - Linear/reserved: load outputs unchanged, out_sat=0, next state OUT.
- MUL, one K bit per cycle, LSB first:
  - Per channel: acc += sign-extended x << counter whenever K[counter]=1.
  - Accumulator width is FIXED_WIDTH+K_W.
  - After counter = K_W-1: go to OUT and load the results.
- Result arithmetic: (acc + 2^(K_FRAC-1)) >>> K_FRAC (round half up), then saturate to [-2^(FW-1), 2^(FW-1)-1]. out_sat = OR of the clip events.
- Vectoring mode: only out1 (magnitude) is scaled. out2 (angle/ratio) passes through unchanged and never saturates.
- Latency:
  - in_valid sampled in cycle 0 → out_valid=1 in cycle K_W+1 (19) for circular/hyperbolic.
  - Linear/reserved: out_valid=1 in cycle 1.
- OUT:
  - Outputs are stable while out_valid=1.
  - out_valid && out_ready → IDLE in the next cycle; out_valid drops.
  - No same-cycle accept-and-capture.
- in_valid when state≠IDLE: input dropped, overrun←1, the in-flight operation is unaffected.
- clr_overrun and a drop in the same cycle: overrun stays 1 (set wins).
- busy = (state≠IDLE).

Decomposition:
- cordic_pkg: mode constants (CIRCULAR=0, LINEAR=1, HYPERBOLIC=2), K_CIRC, K_HYP, K_W, K_FRAC, and a state enum typedef.
- One sub-module, cordic_serial_scaler: per-channel accumulator, round and saturate. Instantiated twice and sharing the top-level counter/K-bit select.

Test Plan:
- Circular rotation, in_a=16'h4000, in_b=16'hC000 → cycle 19: out1=16'h26DD, out2=16'hD923, out_sat=0.
- Circular vectoring, in_a=16'h2000, in_b=16'h0C90 → out1=16'h136F, out2=16'h0C90.
- Hyperbolic rotation, in_a=16'h7000, in_b=16'h0000 → out1=16'h7FFF, out2=16'h0000, out_sat=1.
- Linear, in_a=16'h1234, in_b=16'hFEDC → cycle 1: outputs unchanged, out_valid=1.
- Hold out_ready=0 after a circular result and pulse in_valid → result unchanged, overrun=1. Then pulse clr_overrun → overrun=0. Then out_ready=1 → IDLE, busy=0.
- Assert rst at cycle 10 of MUL → next cycle IDLE, out_valid=0, outputs 0. A fresh circular op then completes normally 19 cycles after its in_valid.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared constants and types for the CORDIC gain compensation stage.
package cordic_pkg;

  localparam int K_W    = 18;
  localparam int K_FRAC = 16;

  // Unsigned Q2.16 reciprocals of the circular and hyperbolic CORDIC gains.
  localparam logic [K_W-1:0] K_CIRC = 18'h09B75;
  localparam logic [K_W-1:0] K_HYP  = 18'h1351E;

  localparam logic [1:0] CIRCULAR   = 2'd0;
  localparam logic [1:0] LINEAR     = 2'd1;
  localparam logic [1:0] HYPERBOLIC = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_OUT  = 2'd2
  } state_e;

endpackage

// File: rtl/cordic_serial_scaler.sv
// One channel of the serial shift-add multiply by K, with round-half-up and
// saturation back to the data width. A bypass load passes a value through.
module cordic_serial_scaler #(
  parameter int FW = 16,
  parameter int KW = 18,
  parameter int KF = 16,
  parameter int CW = $clog2(KW)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear_i,
  input  logic                 step_i,
  input  logic                 k_bit_i,
  input  logic [CW-1:0]        shift_i,
  input  logic signed [FW-1:0] x_i,
  input  logic signed [FW-1:0] pass_i,
  input  logic                 load_i,
  input  logic                 bypass_i,
  output logic signed [FW-1:0] y_o,
  output logic                 sat_o
);

  localparam int AW = FW + KW;
  localparam logic signed [AW-1:0] RND     = {{(AW-KF){1'b0}}, 1'b1, {(KF-1){1'b0}}};
  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-FW+1){1'b0}}, {(FW-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-FW+1){1'b1}}, {(FW-1){1'b0}}};

  logic signed [AW-1:0] acc_q, acc_d;
  logic signed [AW-1:0] x_ext;
  logic signed [AW-1:0] rounded;
  logic signed [FW-1:0] y_q, clip;
  logic                 sat_q, clip_hi, clip_lo;

  assign x_ext = {{KW{x_i[FW-1]}}, x_i};

  always_comb begin
    acc_d = acc_q;
    if (clear_i) begin
      acc_d = '0;
    end else if (step_i && k_bit_i) begin
      acc_d = acc_q + (x_ext <<< shift_i);
    end
  end

  // NOTE: the result is taken from acc_d so the final partial product is
  // included in the same cycle the load fires, saving a cycle of latency.
  assign rounded = (acc_d + RND) >>> KF;
  assign clip_hi = (rounded > SAT_MAX);
  assign clip_lo = (rounded < SAT_MIN);

  always_comb begin
    clip = rounded[FW-1:0];
    if (clip_hi) begin
      clip = {1'b0, {(FW-1){1'b1}}};
    end else if (clip_lo) begin
      clip = {1'b1, {(FW-1){1'b0}}};
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      y_q   <= '0;
      sat_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      if (load_i) begin
        y_q   <= bypass_i ? pass_i : clip;
        sat_q <= bypass_i ? 1'b0 : (clip_hi | clip_lo);
      end
    end
  end

  assign y_o   = y_q;
  assign sat_o = sat_q;

endmodule

// File: rtl/cordic_gain_comp.sv
// Removes the CORDIC gain from the engine results with a serial multiply by K,
// then holds the rounded/saturated pair on a valid/ready interface.
module cordic_gain_comp
  import cordic_pkg::*;
#(
  parameter int FIXED_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [1:0]                    in_mode,
  input  logic                          in_rotating,
  input  logic signed [FIXED_WIDTH-1:0] in_a,
  input  logic signed [FIXED_WIDTH-1:0] in_b,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [FIXED_WIDTH-1:0] out1,
  output logic signed [FIXED_WIDTH-1:0] out2,
  output logic                          out_sat,
  output logic                          busy,
  output logic                          overrun,
  input  logic                          clr_overrun
);

  localparam int CW = $clog2(K_W);

  state_e                        state_q, state_d;
  logic [CW-1:0]                 cnt_q, cnt_d;
  logic signed [FIXED_WIDTH-1:0] a_q, b_q;
  logic                          hyp_q, rot_q, overrun_q;
  logic                          capture, scaled_mode;
  logic                          start, step, load, bypass_all;
  logic [K_W-1:0]                k_sel;
  logic                          k_bit;
  logic signed [FIXED_WIDTH-1:0] pass_a, pass_b;
  logic                          sat_a, sat_b;

  assign capture     = in_valid && (state_q == ST_IDLE);
  assign scaled_mode = (in_mode == CIRCULAR) || (in_mode == HYPERBOLIC);

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    start      = 1'b0;
    step       = 1'b0;
    load       = 1'b0;
    bypass_all = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (scaled_mode) begin
            start   = 1'b1;
            cnt_d   = '0;
            state_d = ST_MUL;
          end else begin
            load       = 1'b1;
            bypass_all = 1'b1;
            state_d    = ST_OUT;
          end
        end
      end
      ST_MUL: begin
        step  = 1'b1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(K_W - 1)) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = ST_OUT;
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      hyp_q     <= 1'b0;
      rot_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        a_q   <= in_a;
        b_q   <= in_b;
        hyp_q <= (in_mode == HYPERBOLIC);
        rot_q <= in_rotating;
      end
      // A drop in the same cycle as a clear keeps the flag set.
      if (in_valid && (state_q != ST_IDLE)) begin
        overrun_q <= 1'b1;
      end else if (clr_overrun) begin
        overrun_q <= 1'b0;
      end
    end
  end

  assign k_sel  = hyp_q ? K_HYP : K_CIRC;
  assign k_bit  = k_sel[cnt_q];
  assign pass_a = (state_q == ST_IDLE) ? in_a : a_q;
  assign pass_b = (state_q == ST_IDLE) ? in_b : b_q;

  cordic_serial_scaler #(
    .FW(FIXED_WIDTH), .KW(K_W), .KF(K_FRAC), .CW(CW)
  ) u_scale_a (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (start),
    .step_i   (step),
    .k_bit_i  (k_bit),
    .shift_i  (cnt_q),
    .x_i      (a_q),
    .pass_i   (pass_a),
    .load_i   (load),
    .bypass_i (bypass_all),
    .y_o      (out1),
    .sat_o    (sat_a)
  );

  // In vectoring mode the second channel is an angle or ratio and is not scaled.
  cordic_serial_scaler #(
    .FW(FIXED_WIDTH), .KW(K_W), .KF(K_FRAC), .CW(CW)
  ) u_scale_b (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (start),
    .step_i   (step),
    .k_bit_i  (k_bit),
    .shift_i  (cnt_q),
    .x_i      (b_q),
    .pass_i   (pass_b),
    .load_i   (load),
    .bypass_i (bypass_all || !rot_q),
    .y_o      (out2),
    .sat_o    (sat_b)
  );

  assign out_valid = (state_q == ST_OUT);
  assign out_sat   = sat_a | sat_b;
  assign busy      = (state_q != ST_IDLE);
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_cordic_gain_comp.sv
// Directed self-checking bench for cordic_gain_comp with hand-computed results.
module tb_cordic_gain_comp;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [1:0]  in_mode;
  logic        in_rotating;
  logic [15:0] in_a, in_b;
  logic        out_valid, out_ready;
  logic [15:0] out1, out2;
  logic        out_sat, busy, overrun, clr_overrun;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cordic_gain_comp #(.FIXED_WIDTH(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_mode     (in_mode),
    .in_rotating (in_rotating),
    .in_a        (in_a),
    .in_b        (in_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out1        (out1),
    .out2        (out2),
    .out_sat     (out_sat),
    .busy        (busy),
    .overrun     (overrun),
    .clr_overrun (clr_overrun)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents one engine done pulse; returns in cycle 1 after the sampling edge.
  task automatic start_op(input logic [1:0] mode, input logic rot,
                          input logic [15:0] a, input logic [15:0] b);
    in_valid    = 1'b1;
    in_mode     = mode;
    in_rotating = rot;
    in_a        = a;
    in_b        = b;
    tick();
    in_valid = 1'b0;
    in_a     = 16'hDEAD;
    in_b     = 16'hBEEF;
  endtask

  task automatic check_result(input string tag, input logic [15:0] e1,
                              input logic [15:0] e2, input logic es);
    check({tag, ".valid"}, 32'(out_valid), 32'd1);
    check({tag, ".out1"},  32'(out1),      32'(e1));
    check({tag, ".out2"},  32'(out2),      32'(e2));
    check({tag, ".sat"},   32'(out_sat),   32'(es));
  endtask

  task automatic accept(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, ".idle_valid"}, 32'(out_valid), 32'd0);
    check({tag, ".idle_busy"},  32'(busy),      32'd0);
  endtask

  // Runs a scaled op to completion, checking out_valid is low in cycle 18.
  task automatic scaled_op(input string tag, input logic [1:0] mode, input logic rot,
                           input logic [15:0] a, input logic [15:0] b);
    start_op(mode, rot, a, b);
    check({tag, ".busy"}, 32'(busy), 32'd1);
    repeat (17) tick();
    check({tag, ".early"}, 32'(out_valid), 32'd0);
    tick();
  endtask

  initial begin
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_mode     = 2'd0;
    in_rotating = 1'b0;
    in_a        = '0;
    in_b        = '0;
    out_ready   = 1'b0;
    clr_overrun = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();

    check("rst.valid",   32'(out_valid), 32'd0);
    check("rst.out1",    32'(out1),      32'd0);
    check("rst.out2",    32'(out2),      32'd0);
    check("rst.sat",     32'(out_sat),   32'd0);
    check("rst.busy",    32'(busy),      32'd0);
    check("rst.overrun", 32'(overrun),   32'd0);

    // Circular rotation: 16384*0.607253 -> 9949, -16384 -> -9949.
    scaled_op("circ_rot", 2'd0, 1'b1, 16'h4000, 16'hC000);
    check_result("circ_rot", 16'h26DD, 16'hD923, 1'b0);
    accept("circ_rot");

    // Circular vectoring: magnitude scaled, angle untouched.
    scaled_op("circ_vec", 2'd0, 1'b0, 16'h2000, 16'h0C90);
    check_result("circ_vec", 16'h136F, 16'h0C90, 1'b0);
    accept("circ_vec");

    // Hyperbolic rotation, in range: 256*1.207497 -> 309, -256 -> -309.
    scaled_op("hyp_small", 2'd2, 1'b1, 16'h0100, 16'hFF00);
    check_result("hyp_small", 16'h0135, 16'hFECB, 1'b0);
    accept("hyp_small");

    // Hyperbolic rotation clipping high.
    scaled_op("hyp_pos", 2'd2, 1'b1, 16'h7000, 16'h0000);
    check_result("hyp_pos", 16'h7FFF, 16'h0000, 1'b1);
    accept("hyp_pos");

    // Hyperbolic rotation clipping low.
    scaled_op("hyp_neg", 2'd2, 1'b1, 16'h9000, 16'h0000);
    check_result("hyp_neg", 16'h8000, 16'h0000, 1'b1);
    accept("hyp_neg");

    // Linear and reserved modes pass through one cycle after capture.
    start_op(2'd1, 1'b1, 16'h1234, 16'hFEDC);
    check_result("linear", 16'h1234, 16'hFEDC, 1'b0);
    accept("linear");
    start_op(2'd3, 1'b0, 16'h7FFF, 16'h8000);
    check_result("reserved", 16'h7FFF, 16'h8000, 1'b0);
    accept("reserved");

    // Drop during MUL, then drops while holding the result.
    start_op(2'd0, 1'b1, 16'h4000, 16'hC000);
    repeat (4) tick();
    in_valid = 1'b1;
    in_a     = 16'h1111;
    in_b     = 16'h2222;
    tick();
    in_valid = 1'b0;
    check("drop_mul.overrun", 32'(overrun), 32'd1);
    repeat (12) tick();
    check("drop_mul.early", 32'(out_valid), 32'd0);
    tick();
    check_result("drop_mul", 16'h26DD, 16'hD923, 1'b0);
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    check("hold.clr0", 32'(overrun), 32'd0);
    in_valid = 1'b1;
    in_mode  = 2'd1;
    in_a     = 16'h5555;
    tick();
    in_valid = 1'b0;
    check_result("hold", 16'h26DD, 16'hD923, 1'b0);
    check("hold.overrun", 32'(overrun), 32'd1);
    in_valid    = 1'b1;
    clr_overrun = 1'b1;
    tick();
    in_valid    = 1'b0;
    clr_overrun = 1'b0;
    check("hold.set_wins", 32'(overrun), 32'd1);
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    check("hold.clr", 32'(overrun), 32'd0);
    check_result("hold2", 16'h26DD, 16'hD923, 1'b0);
    accept("hold");

    // Reset at counter 10 of MUL aborts the op and clears everything.
    start_op(2'd0, 1'b1, 16'h4000, 16'hC000);
    repeat (3) tick();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (6) tick();
    check("abort.busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort.busy",    32'(busy),      32'd0);
    check("abort.valid",   32'(out_valid), 32'd0);
    check("abort.out1",    32'(out1),      32'd0);
    check("abort.out2",    32'(out2),      32'd0);
    check("abort.overrun", 32'(overrun),   32'd0);
    scaled_op("fresh", 2'd0, 1'b1, 16'h2000, 16'h0C90);
    check_result("fresh", 16'h136F, 16'h07A1, 1'b0);
    accept("fresh");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
